// File: rtl/dircc_types_pkg.sv
// Shared stream types: Avalon-ST beat layout and packet-FIFO framing states.
// Width constants here define the default beat geometry used across the tile.
package dircc_types_pkg;

  localparam int ST_BITS_PER_SYMBOL  = 8;
  localparam int ST_SYMBOLS_PER_BEAT = 4;
  localparam int ST_DATA_WIDTH  =
    ST_BITS_PER_SYMBOL * ST_SYMBOLS_PER_BEAT;
  localparam int ST_EMPTY_WIDTH =
    $clog2(ST_SYMBOLS_PER_BEAT);

  typedef struct packed {
    logic [ST_DATA_WIDTH-1:0]  data;
    logic [ST_EMPTY_WIDTH-1:0] empty;
    logic                      sop;
    logic                      eop;
  } st_beat_t;

  typedef enum logic {
    FRAME_IDLE,
    FRAME_IN_PKT
  } fifo_frame_state_t;

endpackage

// File: rtl/dircc_st_fifo_ram.sv
// Beat storage for the packet FIFO: DEPTH x WIDTH registers, one write port,
// combinational read. Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module dircc_st_fifo_ram
  import dircc_types_pkg::*;
#(
  parameter int WIDTH = $bits(st_beat_t),
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dircc_st_packet_fifo.sv
// Store-and-forward Avalon-ST packet buffer; drops malformed framing and
// falls back to cut-through for packets larger than DEPTH beats.
// Ports: clk, reset (sync, high); input_* sink; output_* source; level;
// framing_error (sticky); cut_through; stat_* (live only when
// DIRCC_PACKET_FIFO_STATS_EN is defined, otherwise tied to 0).
module dircc_st_packet_fifo
  import dircc_types_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = ST_BITS_PER_SYMBOL,
  parameter int SYMBOLS_PER_BEAT = ST_SYMBOLS_PER_BEAT,
  parameter int DEPTH            = 8,
  localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT,
  localparam int EW = $clog2(SYMBOLS_PER_BEAT),
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] input_data,
  input  logic [EW-1:0] input_empty,
  input  logic          input_startofpacket,
  input  logic          input_endofpacket,
  input  logic          input_valid,
  output logic          input_ready,
  output logic [DW-1:0] output_data,
  output logic [EW-1:0] output_empty,
  output logic          output_startofpacket,
  output logic          output_endofpacket,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [LW-1:0] level,
  output logic          framing_error,
  output logic          cut_through,
  output logic [31:0]   stat_packets_in,
  output logic [31:0]   stat_packets_out,
  output logic [LW-1:0] stat_max_level
);

  localparam int BW = DW + EW + 2;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] pkt_count_q, pkt_count_d;
  fifo_frame_state_t state_q, state_d;
  logic framing_error_q, framing_error_d;
  logic cut_through_q, cut_through_d;

  logic [BW-1:0] wdata;
  logic [BW-1:0] rdata;
  logic full, accept, keep, store, drop;
  logic ct_set, ct, out_valid, consume;
  logic eop_in, eop_out;

  assign wdata = {input_data, input_empty,
                  input_startofpacket, input_endofpacket};

  dircc_st_fifo_ram #(
    .WIDTH(BW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (store),
    .waddr(wr_ptr_q),
    .wdata(wdata),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  always_comb begin
    full   = (level_q == FULL_LVL);
    accept = input_valid && !reset && !full;
    keep   = 1'b0;
    unique case (state_q)
      FRAME_IDLE:   keep = input_startofpacket;
      FRAME_IN_PKT: keep = !input_startofpacket;
      default:      keep = 1'b0;
    endcase
    store  = accept && keep;
    drop   = accept && !keep;
    // A full FIFO with no complete packet can only hold part of an
    // oversize packet; stream it out rather than deadlock.
    ct_set = full && (pkt_count_q == '0);
    ct     = cut_through_q || ct_set;
    // Gate on level so cut-through never presents an empty slot.
    out_valid = !reset &&
      ((pkt_count_q != '0) || (ct && (level_q != '0)));
    consume = out_valid && output_ready;
    eop_in  = store && input_endofpacket;
    eop_out = consume && rdata[0];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(store);
    rd_ptr_d = rd_ptr_q + AW'(consume);
    level_d  = level_q + LW'(store) - LW'(consume);
    pkt_count_d = pkt_count_q + LW'(eop_in) - LW'(eop_out);
    framing_error_d = framing_error_q || drop;
    cut_through_d = ct && !eop_out;
    state_d = state_q;
    if (store) begin
      if (input_endofpacket) begin
        state_d = FRAME_IDLE;
      end else begin
        state_d = FRAME_IN_PKT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      pkt_count_q     <= '0;
      state_q         <= FRAME_IDLE;
      framing_error_q <= 1'b0;
      cut_through_q   <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      pkt_count_q     <= pkt_count_d;
      state_q         <= state_d;
      framing_error_q <= framing_error_d;
      cut_through_q   <= cut_through_d;
    end
  end

  assign input_ready   = !reset && !full;
  assign output_valid  = out_valid;
  assign {output_data, output_empty,
          output_startofpacket, output_endofpacket} = rdata;
  assign level         = level_q;
  assign framing_error = framing_error_q;
  assign cut_through   = ct && !reset;

`ifdef DIRCC_PACKET_FIFO_STATS_EN
  logic [31:0]   stat_in_q, stat_in_d;
  logic [31:0]   stat_out_q, stat_out_d;
  logic [LW-1:0] stat_max_q, stat_max_d;

  always_comb begin
    stat_in_d  = stat_in_q + 32'(eop_in);
    stat_out_d = stat_out_q + 32'(eop_out);
    stat_max_d = (level_q > stat_max_q) ? level_q : stat_max_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
      stat_max_q <= '0;
    end else begin
      stat_in_q  <= stat_in_d;
      stat_out_q <= stat_out_d;
      stat_max_q <= stat_max_d;
    end
  end

  assign stat_packets_in  = stat_in_q;
  assign stat_packets_out = stat_out_q;
  assign stat_max_level   = stat_max_q;
`else
  assign stat_packets_in  = '0;
  assign stat_packets_out = '0;
  assign stat_max_level   = '0;
`endif

endmodule

// File: tb/tb_dircc_st_packet_fifo.sv
// Scoreboard bench for dircc_st_packet_fifo: directed packets, queue of
// expected beats popped by an independent output monitor.
module tb_dircc_st_packet_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] input_data;
  logic [1:0]  input_empty;
  logic        input_startofpacket;
  logic        input_endofpacket;
  logic        input_valid;
  logic        input_ready;
  logic [31:0] output_data;
  logic [1:0]  output_empty;
  logic        output_startofpacket;
  logic        output_endofpacket;
  logic        output_valid;
  logic        output_ready;
  logic [3:0]  level;
  logic        framing_error;
  logic        cut_through;
  logic [31:0] stat_packets_in;
  logic [31:0] stat_packets_out;
  logic [3:0]  stat_max_level;

  int vectors = 0;
  int miscompares = 0;
  logic [35:0] exp_q [$];

  always #5 clk = ~clk;

  dircc_st_packet_fifo #(
    .BITS_PER_SYMBOL (8),
    .SYMBOLS_PER_BEAT(4),
    .DEPTH           (8)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .input_data          (input_data),
    .input_empty         (input_empty),
    .input_startofpacket (input_startofpacket),
    .input_endofpacket   (input_endofpacket),
    .input_valid         (input_valid),
    .input_ready         (input_ready),
    .output_data         (output_data),
    .output_empty        (output_empty),
    .output_startofpacket(output_startofpacket),
    .output_endofpacket  (output_endofpacket),
    .output_valid        (output_valid),
    .output_ready        (output_ready),
    .level               (level),
    .framing_error       (framing_error),
    .cut_through         (cut_through),
    .stat_packets_in     (stat_packets_in),
    .stat_packets_out    (stat_packets_out),
    .stat_max_level      (stat_max_level)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: a handshake seen at the negedge completes at the
  // following posedge, since inputs only change just after posedges.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && output_valid && output_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(output_data), 64'hFFFF_FFFF);
        end else begin
          chk("beat", 64'({output_data, output_empty,
                           output_startofpacket,
                           output_endofpacket}),
              64'(exp_q.pop_front()));
        end
      end
    end
  end

  // Drive one beat from posedge+1, hold until accepted, return at
  // posedge+1 with valid low. stored=1 pushes it to the scoreboard.
  task automatic send(input logic [31:0] d, input logic [1:0] e,
                      input logic s, input logic eo,
                      input logic stored);
    int n;
    n = 0;
    if (stored) exp_q.push_back({d, e, s, eo});
    input_data = d;
    input_empty = e;
    input_startofpacket = s;
    input_endofpacket = eo;
    input_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (input_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    input_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (level == 4'd0 && !output_valid) break;
      n++;
      if (n > 200) begin
        chk(name, 64'(level), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    input_data = '0;
    input_empty = '0;
    input_startofpacket = 1'b0;
    input_endofpacket = 1'b0;
    input_valid = 1'b0;
    output_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(input_ready), 64'd0);
    chk("rst_out_valid", 64'(output_valid), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_in_ready_after", 64'(input_ready), 64'd1);
    chk("rst_out_valid_after", 64'(output_valid), 64'd0);
    chk("rst_ferr", 64'(framing_error), 64'd0);
    chk("rst_ct", 64'(cut_through), 64'd0);
    @(posedge clk);
    #1;

    // Store-and-forward hold-back with level trace 1,2,3,2,1,0.
    output_ready = 1'b1;
    exp_q.push_back({32'h1000_0000, 2'd0, 1'b1, 1'b0});
    exp_q.push_back({32'h1000_0001, 2'd0, 1'b0, 1'b0});
    exp_q.push_back({32'h1000_0002, 2'd1, 1'b0, 1'b1});
    input_valid = 1'b1;
    {input_data, input_empty} = {32'h1000_0000, 2'd0};
    {input_startofpacket, input_endofpacket} = 2'b10;
    @(negedge clk);
    chk("hb_ov0", 64'(output_valid), 64'd0);
    @(posedge clk);
    #1;
    {input_data, input_empty} = {32'h1000_0001, 2'd0};
    {input_startofpacket, input_endofpacket} = 2'b00;
    @(negedge clk);
    chk("hb_lvl1", 64'(level), 64'd1);
    chk("hb_ov1", 64'(output_valid), 64'd0);
    @(posedge clk);
    #1;
    {input_data, input_empty} = {32'h1000_0002, 2'd1};
    {input_startofpacket, input_endofpacket} = 2'b01;
    @(negedge clk);
    chk("hb_lvl2", 64'(level), 64'd2);
    chk("hb_ov2", 64'(output_valid), 64'd0);
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    @(negedge clk);
    chk("hb_lvl3", 64'(level), 64'd3);
    chk("hb_ov3", 64'(output_valid), 64'd1);
    @(negedge clk);
    chk("hb_lvl2b", 64'(level), 64'd2);
    chk("hb_ov4", 64'(output_valid), 64'd1);
    @(negedge clk);
    chk("hb_lvl1b", 64'(level), 64'd1);
    chk("hb_ov5", 64'(output_valid), 64'd1);
    @(negedge clk);
    chk("hb_lvl0", 64'(level), 64'd0);
    chk("hb_ov6", 64'(output_valid), 64'd0);
    @(posedge clk);
    #1;

    // Full and back-pressure: two 4-beat packets with the sink stalled.
    output_ready = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int b = 0; b < 4; b++) begin
        send(32'h2000_0000 + 32'(p * 16 + b), 2'(b), b == 0, b == 3,
             1'b1);
      end
    end
    @(negedge clk);
    chk("full_lvl", 64'(level), 64'd8);
    chk("full_rdy", 64'(input_ready), 64'd0);
    chk("full_ov", 64'(output_valid), 64'd1);
    @(posedge clk);
    #1;
    output_ready = 1'b1;
    @(negedge clk);
    chk("full_no_bypass", 64'(input_ready), 64'd0);
    @(negedge clk);
    chk("full_rdy_back", 64'(input_ready), 64'd1);
    chk("full_lvl7", 64'(level), 64'd7);
    @(posedge clk);
    #1;
    wait_empty("full_drain");

    // Eop stored while another eop is consumed: no bubble.
    output_ready = 1'b0;
    send(32'h3000_00A0, 2'd0, 1'b1, 1'b0, 1'b1);
    send(32'h3000_00A1, 2'd2, 1'b0, 1'b1, 1'b1);
    send(32'h3000_00B0, 2'd0, 1'b1, 1'b0, 1'b1);
    output_ready = 1'b1;
    @(negedge clk);
    chk("sim_ov_a0", 64'(output_valid), 64'd1);
    @(posedge clk);
    #1;
    exp_q.push_back({32'h3000_00B1, 2'd3, 1'b0, 1'b1});
    {input_data, input_empty} = {32'h3000_00B1, 2'd3};
    {input_startofpacket, input_endofpacket} = 2'b01;
    input_valid = 1'b1;
    @(negedge clk);
    chk("sim_ov_a1", 64'(output_valid), 64'd1);
    chk("sim_rdy", 64'(input_ready), 64'd1);
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    @(negedge clk);
    chk("sim_ov_b0", 64'(output_valid), 64'd1);
    @(negedge clk);
    chk("sim_ov_b1", 64'(output_valid), 64'd1);
    @(negedge clk);
    chk("sim_ov_end", 64'(output_valid), 64'd0);
    chk("sim_lvl_end", 64'(level), 64'd0);
    @(posedge clk);
    #1;

    // Framing: orphan beat in IDLE, then a stray sop inside a packet.
    output_ready = 1'b0;
    send(32'h4000_0BAD, 2'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fe_lvl", 64'(level), 64'd0);
    chk("fe_flag", 64'(framing_error), 64'd1);
    chk("fe_ov", 64'(output_valid), 64'd0);
    @(posedge clk);
    #1;
    send(32'h4100_0000, 2'd0, 1'b1, 1'b0, 1'b1);
    send(32'h4100_0001, 2'd0, 1'b0, 1'b0, 1'b1);
    send(32'h4100_0BAD, 2'd1, 1'b1, 1'b0, 1'b0);
    send(32'h4100_0002, 2'd3, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("fe_pkt_lvl", 64'(level), 64'd3);
    chk("fe_pkt_ov", 64'(output_valid), 64'd1);
    @(posedge clk);
    #1;
    output_ready = 1'b1;
    wait_empty("fe_drain");

    // Oversize: 12-beat packet through an 8-deep FIFO.
    output_ready = 1'b0;
    for (int b = 0; b < 8; b++) begin
      send(32'h5000_0000 + 32'(b), 2'd0, b == 0, 1'b0, 1'b1);
    end
    @(negedge clk);
    chk("ov_lvl", 64'(level), 64'd8);
    chk("ov_ct", 64'(cut_through), 64'd1);
    chk("ov_valid", 64'(output_valid), 64'd1);
    @(posedge clk);
    #1;
    output_ready = 1'b1;
    for (int b = 8; b < 12; b++) begin
      send(32'h5000_0000 + 32'(b), 2'd0, 1'b0, b == 11, 1'b1);
    end
    wait_empty("ov_drain");
    @(negedge clk);
    chk("ov_ct_clr", 64'(cut_through), 64'd0);
    chk("ov_q_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Reset mid-packet, then a lone 1-beat packet.
    output_ready = 1'b0;
    send(32'h6000_0000, 2'd0, 1'b1, 1'b0, 1'b0);
    send(32'h6000_0001, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rdy_in_rst", 64'(input_ready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mr_lvl", 64'(level), 64'd0);
    chk("mr_ov", 64'(output_valid), 64'd0);
    chk("mr_ferr", 64'(framing_error), 64'd0);
    @(posedge clk);
    #1;
    output_ready = 1'b1;
    send(32'h6100_0042, 2'd2, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("mr_ov_1beat", 64'(output_valid), 64'd1);
    chk("mr_sop", 64'(output_startofpacket), 64'd1);
    @(posedge clk);
    #1;
    wait_empty("mr_drain");
    chk("mr_q_empty", 64'(exp_q.size()), 64'd0);
`ifdef DIRCC_PACKET_FIFO_STATS_EN
    chk("stat_in", 64'(stat_packets_in), 64'd1);
    chk("stat_out", 64'(stat_packets_out), 64'd1);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dircc_st_packet_fifo.md
# dircc_st_packet_fifo

Store-and-forward Avalon-ST packet buffer between the network fabric and the processing element's stream input. It accepts beats, stores them, and presents a packet downstream only after its endofpacket beat has been stored. The processing element's packet receiver therefore always sees each packet as an unbroken run of beats, with no bubbles. The block also drops and flags malformed framing so that it never reaches the receiver.

## Interface
- BITS_PER_SYMBOL, 8: bits per symbol.
- SYMBOLS_PER_BEAT, 4: symbols per beat. DATA_WIDTH = product; EMPTY_WIDTH = $clog2(SYMBOLS_PER_BEAT).
- DEPTH, 8: storage in beats. Must be a power of 2 and ≥ 2.
- clk  in  1  clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset.
- input_data / input_empty / input_startofpacket / input_endofpacket  in  DATA_WIDTH / EMPTY_WIDTH / 1 / 1  sink beat.
- input_valid  in  1  sink beat valid.
- input_ready  out  1  sink ready (ready latency 0).
- output_data / output_empty / output_startofpacket / output_endofpacket  out  same widths  source beat.
- output_valid  out  1  source beat valid.
- output_ready  in  1  source ready (ready latency 0).
- level  out  $clog2(DEPTH)+1  beats currently stored.
- framing_error  out  1  sticky; set on any dropped beat.
- cut_through  out  1  high while the oversize-packet fallback is active.
- stat_packets_in, stat_packets_out  out  32 each  packet counters; only meaningful with the macro.
- stat_max_level  out  $clog2(DEPTH)+1  occupancy high-water mark; only meaningful with the macro.

## Operation
- Each stored entry is {data, empty, sop, eop}. Write and read pointers are $clog2(DEPTH) bits and wrap naturally.
- **Beat accepted:** input_valid && input_ready. input_ready = (level != DEPTH).
- **Beat consumed:** output_valid && output_ready.
- **Input framing tracker** (state IDLE / IN_PKT):
  - IDLE + accepted beat with sop: store it. If eop is also set, the packet is complete and the state stays IDLE; otherwise go to IN_PKT.
  - IDLE + accepted beat without sop: drop it (not stored), set framing_error, stay IDLE.
  - IN_PKT + beat with sop: drop it, set framing_error, stay IN_PKT. The open packet continues.
  - IN_PKT + beat with eop (and no sop): store it, packet complete, go to IDLE.
  - Dropped beats still complete the handshake; input_ready is unaffected by a drop.
- **Completed-packet count** (pkt_count, $clog2(DEPTH)+1 bits):
  - +1 when an eop beat is stored.
  - −1 when an eop beat is consumed.
  - Both in the same cycle: unchanged.
- **Output:**
  - output_* come directly from entry[rd_ptr] (show-ahead).
  - output_valid = (pkt_count != 0) || cut_through.
  - The consumer may stall at any beat; output_* then hold stable.
- **Oversize fallback:**
  - cut_through sets when level == DEPTH && pkt_count == 0, which means a packet larger than DEPTH would otherwise deadlock.
  - While set, beats stream out as they arrive.
  - cut_through clears in the cycle the eop beat of that packet is consumed.
  - Bubbles inside that packet are permitted.
- **Reset:**
  - Pointers, level, pkt_count, state, framing_error, cut_through and all stat outputs are cleared to 0.
  - input_ready = 0 during reset; it is 1 from the first cycle after reset.
  - output_valid = 0. output_data/empty/sop/eop are don't-care while output_valid = 0.
  - Reset mid-packet discards all stored content, including any partial packet.

## Timing
- **Latency:** an eop beat stored at edge N gives output_valid = 1 in the cycle after edge N, presenting the packet's first beat. A single-beat packet therefore has 1-cycle latency.
- **Throughput:** one beat per cycle in each direction, simultaneously.
- **Full:** input_ready is low when level == DEPTH. A read in that same cycle does not raise input_ready; there is no bypass, and ready rises the following cycle.
- **Empty:** with level == 0, a stored beat is never forwarded in its own write cycle.
- **level update:** level = level + accepted-and-stored − consumed, registered. Dropped beats do not count.

## Configuration
- Macro: DIRCC_PACKET_FIFO_STATS_EN.
- **Defined:**
  - stat_packets_in increments on each stored eop beat.
  - stat_packets_out increments on each consumed eop beat.
  - Both counters wrap at 2^32.
  - stat_max_level tracks the maximum registered level.
- **Undefined:** the stat ports remain present but are tied to 0, and no counter logic is generated.

## Structure
- The shared package dircc_types_pkg gains:
  - typedef st_beat_t (data, empty, sop, eop), parameterised through the package's existing width constants;
  - enum fifo_frame_state_t {FRAME_IDLE, FRAME_IN_PKT}.
- One sub-module, dircc_st_fifo_ram: a DEPTH × $bits(st_beat_t) register array with one write port and a combinational read port. It holds no control logic; all control stays in the top-level module.

## Test plan
- **Store-and-forward hold-back:** 3-beat packet (sop on beat 0, eop on beat 2) into an empty FIFO → output_valid stays 0 through the cycle of the beat-2 write and is 1 in the next cycle. The beats come out as 3 consecutive beats with output_ready = 1, with level sequence 1,2,3,2,1,0.
- **Full and back-pressure:** DEPTH=8, two 4-beat packets with output_ready = 0 → input_ready = 0 once level = 8. Raising output_ready gives input_ready = 1 one cycle after the first consume.
- **Simultaneous eop in/out:** one packet streaming out while another's eop is written in the same cycle → pkt_count unchanged, output_valid remains 1, no bubble.
- **Framing errors:**
  - Beat without sop while IDLE → dropped, level unchanged, framing_error = 1.
  - A sop beat inside a packet → dropped; the packet completes normally with its original beat count.
- **Oversize packet:** 12-beat packet with DEPTH=8 → cut_through = 1 when level reaches 8. All 12 beats are delivered in order, and cut_through = 0 after the eop is consumed.
- **Reset mid-packet and stats:**
  - Reset pulse after 2 of 4 beats → level = 0 and output_valid = 0 after reset. A following 1-beat packet emerges alone.
  - With DIRCC_PACKET_FIFO_STATS_EN defined, stat_packets_in = stat_packets_out = 1 at the end.
